// File: rtl/ysyx_25060170_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// FSM state encoding and the default outstanding-fetch limit.
package ysyx_25060170_pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    LS_WAIT = 1'b1
  } pipe_state_e;

  localparam int FETCH_OUTST_MAX_DEF = 2;
  localparam int OUTST_W             = 3;

endpackage

// File: rtl/ysyx_25060170_sat_cnt.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module ysyx_25060170_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ysyx_25060170_pipe_ctrl.sv
// Central hazard controller: load-use, LS memory waits, redirects, traps, fetch discard.
// Optional performance counters are built when YSYX_25060170_PIPE_PERF_EN is defined.
module ysyx_25060170_pipe_ctrl
  import ysyx_25060170_pipe_ctrl_pkg::*;
#(
  parameter int FETCH_OUTST_MAX = FETCH_OUTST_MAX_DEF,
  parameter int PERF_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic              id_rs1_ren,
  input  logic              id_rs2_ren,
  input  logic [4:0]        ex_rd_addr,
  input  logic              ex_rd_ena,
  input  logic              ex_is_load,
  input  logic              ex_redirect,
  input  logic              ls_mem_req,
  input  logic              ls_mem_done,
  input  logic              ls_trap,
  input  logic              if_req_fire,
  input  logic              if_resp_valid,
  output logic              if_hold,
  output logic              id_hold,
  output logic              ex_hold,
  output logic              ls_hold,
  output logic              id_flush,
  output logic              ie_flush,
  output logic              ls_flush,
  output logic              if_resp_drop,
  output logic [PERF_W-1:0] perf_ls_wait,
  output logic [PERF_W-1:0] perf_load_use,
  output logic [PERF_W-1:0] perf_flush
);

  pipe_state_e        state_q, state_d;
  logic [OUTST_W-1:0] outst_q, outst_d;
  logic [OUTST_W-1:0] drop_cnt_q, drop_cnt_d;

  logic mem_hold;
  logic trap_acc;
  logic redir_acc;
  logic flush_acc;
  logic load_use;
  logic load_use_act;
  logic fetch_full;
  logic resp_drop;

  always_comb begin
    state_d    = state_q;
    outst_d    = outst_q + OUTST_W'(if_req_fire) - OUTST_W'(if_resp_valid);
    drop_cnt_d = drop_cnt_q;

    mem_hold = (state_q == RUN) ? (ls_mem_req & ~ls_mem_done) : ~ls_mem_done;

    // A held redirect stays on the EX input, so it is simply picked up once mem_hold drops.
    trap_acc  = ~mem_hold & ls_trap;
    redir_acc = ~mem_hold & ex_redirect & ~ls_trap;
    flush_acc = trap_acc | redir_acc;

    load_use = ex_is_load & ex_rd_ena & (ex_rd_addr != 5'd0) &
               ((id_rs1_ren & (id_rs1_addr == ex_rd_addr)) |
                (id_rs2_ren & (id_rs2_addr == ex_rd_addr)));
    load_use_act = load_use & ~mem_hold & ~flush_acc;

    fetch_full = (outst_q == OUTST_W'(FETCH_OUTST_MAX));
    resp_drop  = if_resp_valid & (drop_cnt_q != '0);

    case (state_q)
      RUN:     if (ls_mem_req & ~ls_mem_done) state_d = LS_WAIT;
      LS_WAIT: if (ls_mem_done) state_d = RUN;
      default: state_d = RUN;
    endcase

    // Everything already requested (including this cycle's fire) belongs to the dead path.
    if (flush_acc) begin
      drop_cnt_d = outst_d;
    end else if (resp_drop) begin
      drop_cnt_d = drop_cnt_q - OUTST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      outst_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      outst_q    <= outst_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign if_hold      = ~rst & (mem_hold | load_use_act | fetch_full);
  assign id_hold      = ~rst & (mem_hold | load_use_act);
  assign ex_hold      = ~rst & mem_hold;
  assign ls_hold      = ~rst & mem_hold;
  assign id_flush     = ~rst & flush_acc;
  assign ie_flush     = ~rst & (flush_acc | load_use_act);
  assign ls_flush     = ~rst & trap_acc;
  assign if_resp_drop = ~rst & resp_drop;

`ifdef YSYX_25060170_PIPE_PERF_EN
  logic [PERF_W-1:0] ls_wait_cnt;
  logic [PERF_W-1:0] load_use_cnt;
  logic [PERF_W-1:0] flush_cnt;

  ysyx_25060170_sat_cnt #(.W(PERF_W)) u_cnt_ls_wait (
    .clk (clk),
    .rst (rst),
    .inc (mem_hold),
    .cnt (ls_wait_cnt)
  );

  ysyx_25060170_sat_cnt #(.W(PERF_W)) u_cnt_load_use (
    .clk (clk),
    .rst (rst),
    .inc (load_use_act),
    .cnt (load_use_cnt)
  );

  ysyx_25060170_sat_cnt #(.W(PERF_W)) u_cnt_flush (
    .clk (clk),
    .rst (rst),
    .inc (flush_acc),
    .cnt (flush_cnt)
  );

  assign perf_ls_wait  = rst ? '0 : ls_wait_cnt;
  assign perf_load_use = rst ? '0 : load_use_cnt;
  assign perf_flush    = rst ? '0 : flush_cnt;
`else
  assign perf_ls_wait  = '0;
  assign perf_load_use = '0;
  assign perf_flush    = '0;
`endif

endmodule

// File: tb/tb_ysyx_25060170_pipe_ctrl.sv
// Directed + randomized bench for ysyx_25060170_pipe_ctrl, checked against a
// cycle-level reference model (integer counters, boolean rules) kept here.
module tb_ysyx_25060170_pipe_ctrl;

  localparam int MAXO = 2;
  localparam int PW   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic          id_rs1_ren, id_rs2_ren, ex_rd_ena, ex_is_load, ex_redirect;
  logic          ls_mem_req, ls_mem_done, ls_trap, if_req_fire, if_resp_valid;
  logic          if_hold, id_hold, ex_hold, ls_hold;
  logic          id_flush, ie_flush, ls_flush, if_resp_drop;
  logic [PW-1:0] perf_ls_wait, perf_load_use, perf_flush;

  ysyx_25060170_pipe_ctrl #(.FETCH_OUTST_MAX(MAXO), .PERF_W(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_rs1_ren    (id_rs1_ren),
    .id_rs2_ren    (id_rs2_ren),
    .ex_rd_addr    (ex_rd_addr),
    .ex_rd_ena     (ex_rd_ena),
    .ex_is_load    (ex_is_load),
    .ex_redirect   (ex_redirect),
    .ls_mem_req    (ls_mem_req),
    .ls_mem_done   (ls_mem_done),
    .ls_trap       (ls_trap),
    .if_req_fire   (if_req_fire),
    .if_resp_valid (if_resp_valid),
    .if_hold       (if_hold),
    .id_hold       (id_hold),
    .ex_hold       (ex_hold),
    .ls_hold       (ls_hold),
    .id_flush      (id_flush),
    .ie_flush      (ie_flush),
    .ls_flush      (ls_flush),
    .if_resp_drop  (if_resp_drop),
    .perf_ls_wait  (perf_ls_wait),
    .perf_load_use (perf_load_use),
    .perf_flush    (perf_flush)
  );

  // Reference model state
  bit     m_wait;
  int     m_outst;
  int     m_drop;
  longint m_pl, m_pu, m_pf;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0;
    id_rs1_ren = 0; id_rs2_ren = 0; ex_rd_ena = 0; ex_is_load = 0;
    ex_redirect = 0; ls_mem_req = 0; ls_mem_done = 0; ls_trap = 0;
    if_req_fire = 0; if_resp_valid = 0;
  endtask

  function automatic longint sat(input longint v);
    longint lim;
    lim = (64'd1 << PW) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // Check this cycle's outputs against the model, then advance one clock.
  task automatic cyc(input string label, input bit verbose);
    bit mh, tr, rd, lu, lua, fl, full, drp;
    #3;
    mh   = m_wait ? !ls_mem_done : (ls_mem_req && !ls_mem_done);
    tr   = !mh && ls_trap;
    rd   = !mh && ex_redirect && !ls_trap;
    fl   = tr || rd;
    lu   = ex_is_load && ex_rd_ena && ex_rd_addr != 0 &&
           ((id_rs1_ren && id_rs1_addr == ex_rd_addr) || (id_rs2_ren && id_rs2_addr == ex_rd_addr));
    lua  = lu && !mh && !fl;
    full = (m_outst == MAXO);
    drp  = if_resp_valid && m_drop > 0;
    if (rst) begin
      mh = 0; tr = 0; rd = 0; fl = 0; lua = 0; full = 0; drp = 0;
    end
    if (verbose)
      $display("step %-14s ifh=%0b idh=%0b exh=%0b lsh=%0b idf=%0b ief=%0b lsf=%0b drop=%0b outst=%0d",
               label, if_hold, id_hold, ex_hold, ls_hold, id_flush, ie_flush, ls_flush, if_resp_drop, m_outst);
    chk({label, ".if_hold"},      PW'(if_hold),      PW'(mh || lua || full));
    chk({label, ".id_hold"},      PW'(id_hold),      PW'(mh || lua));
    chk({label, ".ex_hold"},      PW'(ex_hold),      PW'(mh));
    chk({label, ".ls_hold"},      PW'(ls_hold),      PW'(mh));
    chk({label, ".id_flush"},     PW'(id_flush),     PW'(fl));
    chk({label, ".ie_flush"},     PW'(ie_flush),     PW'(fl || lua));
    chk({label, ".ls_flush"},     PW'(ls_flush),     PW'(tr));
    chk({label, ".if_resp_drop"}, PW'(if_resp_drop), PW'(drp));
`ifdef YSYX_25060170_PIPE_PERF_EN
    chk({label, ".perf_ls_wait"},  perf_ls_wait,  rst ? '0 : PW'(sat(m_pl)));
    chk({label, ".perf_load_use"}, perf_load_use, rst ? '0 : PW'(sat(m_pu)));
    chk({label, ".perf_flush"},    perf_flush,    rst ? '0 : PW'(sat(m_pf)));
`else
    chk({label, ".perf_ls_wait"},  perf_ls_wait,  '0);
    chk({label, ".perf_load_use"}, perf_load_use, '0);
    chk({label, ".perf_flush"},    perf_flush,    '0);
`endif
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_outst = 0; m_drop = 0; m_pl = 0; m_pu = 0; m_pf = 0;
    end else begin
      m_wait  = m_wait ? !ls_mem_done : (ls_mem_req && !ls_mem_done);
      m_outst = m_outst + int'(if_req_fire) - int'(if_resp_valid);
      if (fl) m_drop = m_outst;
      else if (drp) m_drop = m_drop - 1;
      if (mh)  m_pl++;
      if (lua) m_pu++;
      if (fl)  m_pf++;
    end
    #1;
  endtask

  initial begin
    m_wait = 0; m_outst = 0; m_drop = 0; m_pl = 0; m_pu = 0; m_pf = 0;
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    cyc("reset", 1);
    cyc("reset", 1);
    rst = 0;
    cyc("post_reset", 1);

    // Load-use via rs2
    ex_is_load = 1; ex_rd_ena = 1; ex_rd_addr = 5; id_rs2_ren = 1; id_rs2_addr = 5;
    cyc("load_use", 1);
    idle();
    cyc("load_use_gone", 1);

    // Load to x0 never stalls
    ex_is_load = 1; ex_rd_ena = 1; ex_rd_addr = 0; id_rs1_ren = 1; id_rs1_addr = 0;
    cyc("load_x0", 1);
    idle();

    // Memory wait: req pulse, done 4 cycles later
    ls_mem_req = 1;
    cyc("mem_req", 1);
    ls_mem_req = 0;
    for (int i = 0; i < 3; i++) cyc("mem_wait", 1);
    ls_mem_done = 1;
    cyc("mem_done", 1);
    ls_mem_done = 0;
    cyc("mem_after", 1);

    // Redirect with two fetches in flight
    if_req_fire = 1;
    cyc("fire", 1);
    cyc("fire", 1);
    if_req_fire = 0;
    ex_redirect = 1;
    cyc("redirect", 1);
    ex_redirect = 0;
    cyc("redir_gap", 1);
    if_resp_valid = 1;
    cyc("resp_drop1", 1);
    cyc("resp_drop2", 1);
    if_resp_valid = 0;
    if_req_fire = 1;
    cyc("fire", 1);
    if_req_fire = 0; if_resp_valid = 1;
    cyc("resp_keep", 1);
    if_resp_valid = 0;

    // Redirect and trap together
    ex_redirect = 1; ls_trap = 1;
    cyc("redir_trap", 1);
    idle();
    cyc("after_trap", 1);

    // Redirect during LS_WAIT waits for done
    ls_mem_req = 1;
    cyc("mem_req2", 1);
    ls_mem_req = 0; ex_redirect = 1;
    cyc("redir_in_wait", 1);
    cyc("redir_in_wait", 1);
    ls_mem_done = 1;
    cyc("redir_at_done", 1);
    idle();
    cyc("idle", 1);

    // Reset mid-LS_WAIT
    ls_mem_req = 1;
    cyc("mem_req3", 1);
    ls_mem_req = 0;
    cyc("mem_wait3", 1);
    rst = 1;
    cyc("rst_in_wait", 1);
    rst = 0;
    cyc("after_rst", 1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst           = ($urandom_range(0, 79) == 0);
      ls_mem_req    = !m_wait && ($urandom_range(0, 4) == 0);
      ls_mem_done   = m_wait ? ($urandom_range(0, 2) == 0)
                             : (ls_mem_req && $urandom_range(0, 3) == 0);
      ex_redirect   = ($urandom_range(0, 5) == 0);
      ls_trap       = ($urandom_range(0, 9) == 0);
      if_req_fire   = (m_outst < MAXO) && ($urandom_range(0, 1) == 1);
      if_resp_valid = (m_outst > 0) && ($urandom_range(0, 1) == 1);
      ex_is_load    = ($urandom_range(0, 1) == 1);
      ex_rd_ena     = ($urandom_range(0, 3) != 0);
      ex_rd_addr    = 5'($urandom_range(0, 3));
      id_rs1_addr   = 5'($urandom_range(0, 3));
      id_rs2_addr   = 5'($urandom_range(0, 3));
      id_rs1_ren    = ($urandom_range(0, 1) == 1);
      id_rs2_ren    = ($urandom_range(0, 1) == 1);
      cyc("random", 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
